// File: rtl/corr_acc_nc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// corr_acc_nc_pkg : unsigned saturation helpers and non-coherent state codes.
// Rev 1.0
// ----------------------------------------------------------------------------
package corr_acc_nc_pkg;

    localparam int SAT_W = 128;

    typedef enum logic [0:0] {
        NC_IDLE = 1'b0,
        NC_ACC  = 1'b1
    } nc_state_e;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] val;
    } sat_t;

    function automatic logic [SAT_W-1:0] sat_mask(input int w);
        return {SAT_W{1'b1}} >> (SAT_W - w);
    endfunction

    // Clamp an unsigned value to the all-ones of a w-bit field.
    function automatic sat_t sat_trunc(input logic [SAT_W-1:0] v, input int w);
        sat_t             r;
        logic [SAT_W-1:0] m;
        m     = sat_mask(w);
        r.ovf = |(v & ~m);
        r.val = r.ovf ? m : v;
        return r;
    endfunction

    function automatic sat_t sat_add(input logic [SAT_W-1:0] a,
                                     input logic [SAT_W-1:0] b,
                                     input int               w);
        sat_t             r;
        logic [SAT_W:0]   s;
        logic [SAT_W-1:0] m;
        m     = sat_mask(w);
        s     = {1'b0, a} + {1'b0, b};
        r.ovf = (s > {1'b0, m});
        r.val = r.ovf ? m : s[SAT_W-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/corr_pow2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// corr_pow2 : two-stage pipelined re^2 + im^2 with saturation to POW_WIDTH.
// Rev 1.0
// ----------------------------------------------------------------------------
module corr_pow2
    import corr_acc_nc_pkg::*;
#(
    parameter int CORR_WIDTH = 32,
    parameter int POW_WIDTH  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         vld_i,
    input  logic signed [CORR_WIDTH-1:0] re_i,
    input  logic signed [CORR_WIDTH-1:0] im_i,
    output logic                         vld_o,
    output logic        [POW_WIDTH-1:0]  pow_o,
    output logic                         ovf_o
);

    localparam int SQ_W = 2 * CORR_WIDTH;

    logic signed [SQ_W-1:0] sq_re_q;
    logic signed [SQ_W-1:0] sq_im_q;
    logic                   vld1_q;
    logic        [SQ_W:0]   sum_d;
    sat_t                   sat_d;

    // Squares are non-negative, so the exact sum needs one extra bit only.
    assign sum_d = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    assign sat_d = sat_trunc(SAT_W'(sum_d), POW_WIDTH);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld1_q  <= 1'b0;
            vld_o   <= 1'b0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            pow_o   <= '0;
            ovf_o   <= 1'b0;
        end else begin
            vld1_q <= vld_i;
            vld_o  <= vld1_q;
            if (vld_i) begin
                sq_re_q <= SQ_W'(re_i) * SQ_W'(re_i);
                sq_im_q <= SQ_W'(im_i) * SQ_W'(im_i);
            end
            if (vld1_q) begin
                pow_o <= POW_WIDTH'(sat_d.val);
                ovf_o <= sat_d.ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/corr_acc_nc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// corr_acc_nc : multi-tap coherent correlator with non-coherent power summing.
// Rev 1.0
// ----------------------------------------------------------------------------
module corr_acc_nc
    import corr_acc_nc_pkg::*;
#(
    parameter int  DAT_WIDTH  = 16,
    parameter int  CORR_WIDTH = 32,
    parameter int  POW_WIDTH  = 64,
    parameter int  NUM_TAPS   = 3,
    parameter int  NCOH_MAX   = 16,
    localparam int NCW        = $clog2(NCOH_MAX + 1)
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst_n,
    input  logic                          rx_valid,
    input  logic signed [DAT_WIDTH-1:0]   rx_data_real,
    input  logic signed [DAT_WIDTH-1:0]   rx_data_imag,
    input  logic [NUM_TAPS-1:0]           rx_loc_boc,
    input  logic                          rx_prn_sop,
    input  logic                          rx_prn_eop,
    input  logic [NCW-1:0]                cfg_ncoh_len,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_TAPS*POW_WIDTH-1:0] tx_pow,
    output logic [NUM_TAPS-1:0]           tx_ovf,
    output logic                          tx_drop
);

    logic                         in_vld_q;
    logic                         in_sop_q;
    logic                         in_eop_q;
    logic signed [DAT_WIDTH-1:0]  in_re_q;
    logic signed [DAT_WIDTH-1:0]  in_im_q;
    logic [NUM_TAPS-1:0]          in_boc_q;
    logic                         dump_vld_q;
    logic signed [CORR_WIDTH-1:0] ext_re;
    logic signed [CORR_WIDTH-1:0] ext_im;
    logic [NUM_TAPS-1:0]          pow_vld;

    nc_state_e                    state_q;
    logic [NCW-1:0]               len_q;
    logic [NCW-1:0]               cnt_q;
    logic [NCW-1:0]               len_eff;
    logic [NCW-1:0]               cnt_inc;
    logic                         pow_vld_any;
    logic                         nc_first;
    logic                         nc_cmpl;
    logic                         out_load;
    logic                         tx_valid_q;
    logic                         tx_drop_q;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            in_vld_q   <= 1'b0;
            in_sop_q   <= 1'b0;
            in_eop_q   <= 1'b0;
            in_re_q    <= '0;
            in_im_q    <= '0;
            in_boc_q   <= '0;
            dump_vld_q <= 1'b0;
        end else begin
            in_vld_q   <= rx_valid;
            in_sop_q   <= rx_valid & rx_prn_sop;
            in_eop_q   <= rx_valid & rx_prn_eop;
            dump_vld_q <= in_eop_q;
            if (rx_valid) begin
                in_re_q  <= rx_data_real;
                in_im_q  <= rx_data_imag;
                in_boc_q <= rx_loc_boc;
            end
        end
    end

    assign ext_re = CORR_WIDTH'(in_re_q);
    assign ext_im = CORR_WIDTH'(in_im_q);

    assign pow_vld_any = |pow_vld;
    assign len_eff     = (cfg_ncoh_len == '0)              ? NCW'(1) :
                         (cfg_ncoh_len > NCW'(NCOH_MAX))   ? NCW'(NCOH_MAX) : cfg_ncoh_len;
    assign cnt_inc     = cnt_q + NCW'(1);
    assign nc_first    = (state_q == NC_IDLE);
    assign nc_cmpl     = pow_vld_any && (nc_first ? (len_eff == NCW'(1)) : (cnt_inc == len_q));
    assign out_load    = nc_cmpl && (!tx_valid_q || tx_ready);

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [CORR_WIDTH-1:0] term_re, term_im;
        logic signed [CORR_WIDTH-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
        logic signed [CORR_WIDTH-1:0] snap_re_q, snap_im_q;
        logic [POW_WIDTH-1:0]         pow_res, sum_q, sum_d, out_q;
        logic                         pow_ovf, ovf_q, ovf_d, out_ovf_q;
        sat_t                         add_res;

        assign term_re  = in_boc_q[k] ? ext_re : -ext_re;
        assign term_im  = in_boc_q[k] ? ext_im : -ext_im;
        assign acc_re_d = in_sop_q ? term_re : acc_re_q + term_re;
        assign acc_im_d = in_sop_q ? term_im : acc_im_q + term_im;

        always_ff @(posedge rx_clk or negedge rx_rst_n) begin
            if (!rx_rst_n) begin
                acc_re_q  <= '0;
                acc_im_q  <= '0;
                snap_re_q <= '0;
                snap_im_q <= '0;
            end else begin
                if (in_vld_q) begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                end
                if (in_eop_q) begin
                    snap_re_q <= acc_re_d;
                    snap_im_q <= acc_im_d;
                end
            end
        end

        corr_pow2 #(
            .CORR_WIDTH (CORR_WIDTH),
            .POW_WIDTH  (POW_WIDTH)
        ) u_pow (
            .clk_i   (rx_clk),
            .rst_n_i (rx_rst_n),
            .vld_i   (dump_vld_q),
            .re_i    (snap_re_q),
            .im_i    (snap_im_q),
            .vld_o   (pow_vld[k]),
            .pow_o   (pow_res),
            .ovf_o   (pow_ovf)
        );

        assign add_res = sat_add(SAT_W'(sum_q), SAT_W'(pow_res), POW_WIDTH);
        assign sum_d   = nc_first ? pow_res : POW_WIDTH'(add_res.val);
        assign ovf_d   = nc_first ? pow_ovf : (ovf_q | pow_ovf | add_res.ovf);

        always_ff @(posedge rx_clk or negedge rx_rst_n) begin
            if (!rx_rst_n) begin
                sum_q     <= '0;
                ovf_q     <= 1'b0;
                out_q     <= '0;
                out_ovf_q <= 1'b0;
            end else begin
                if (pow_vld_any) begin
                    sum_q <= sum_d;
                    ovf_q <= ovf_d;
                end
                if (out_load) begin
                    out_q     <= sum_d;
                    out_ovf_q <= ovf_d;
                end
            end
        end

        assign tx_pow[k*POW_WIDTH +: POW_WIDTH] = out_q;
        assign tx_ovf[k]                        = out_ovf_q;
    end

    // Block length is sampled only when a block opens, so cfg edits never split a block.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q    <= NC_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            tx_drop_q <= nc_cmpl && tx_valid_q && !tx_ready;
            if (out_load) begin
                tx_valid_q <= 1'b1;
            end else if (tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            if (pow_vld_any) begin
                case (state_q)
                    NC_IDLE: begin
                        len_q   <= len_eff;
                        cnt_q   <= NCW'(1);
                        state_q <= (len_eff == NCW'(1)) ? NC_IDLE : NC_ACC;
                    end
                    NC_ACC: begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_q <= NC_IDLE;
                        end
                    end
                    default: state_q <= NC_IDLE;
                endcase
            end
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_drop  = tx_drop_q;

endmodule
`default_nettype wire
